dino_motion_fsm: RTL

//  Next-generation dinosaur motion controller. Explicit RUN/DUCK/RISE/FALL state machine with

---
 rtl/dino_motion_if.sv | 39 +++
 rtl/dino_motion_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dino_motion_if.sv
// Dinosaur motion controller bus: frame strobe and button levels in, bounding box,
// state and event pulses out.
//   i_ani_stb    frame strobe
//   i_animate    physics enable
//   i_jump       jump button level
//   i_duck       duck button level
//   i_sss        ultra-jump select
//   o_x1..o_y2   dino bounding box, pixels
//   o_state      0 RUN, 1 DUCK, 2 RISE, 3 FALL
//   o_jump_start one-cycle take-off pulse
//   o_land       one-cycle landing pulse
interface dino_motion_if #(
  parameter int unsigned COORD_W = 12
);
  logic               i_ani_stb;
  logic               i_animate;
  logic               i_jump;
  logic               i_duck;
  logic               i_sss;
  logic [COORD_W-1:0] o_x1;
  logic [COORD_W-1:0] o_x2;
  logic [COORD_W-1:0] o_y1;
  logic [COORD_W-1:0] o_y2;
  logic [1:0]         o_state;
  logic               o_jump_start;
  logic               o_land;

  // Game/input side
  modport master (
    output i_ani_stb, i_animate, i_jump, i_duck, i_sss,
    input  o_x1, o_x2, o_y1, o_y2, o_state, o_jump_start, o_land
  );

  // Motion controller side
  modport slave (
    input  i_ani_stb, i_animate, i_jump, i_duck, i_sss,
    output o_x1, o_x2, o_y1, o_y2, o_state, o_jump_start, o_land
  );
endinterface

// File: rtl/dino_motion_fsm.sv
// Dinosaur motion controller: RUN/DUCK/RISE/FALL state machine with fixed-point
// vertical physics, variable jump height, jump buffer, fall-speed cap and ceiling clamp.
//   i_clk  clock
//   i_rst  synchronous active-high reset
//   bus    dino_motion_if slave: strobe/buttons in, bounding box/state/pulses out
module dino_motion_fsm #(
  parameter int unsigned COORD_W          = 12,
  parameter int unsigned FRAC_W           = 4,
  parameter int unsigned DINO_X           = 80,
  parameter int unsigned DINO_HALF_W      = 20,
  parameter int unsigned DINO_HALF_H      = 30,
  parameter int unsigned DINO_DUCK_HALF_H = 20,
  parameter int unsigned FLOOR_Y          = 400,
  parameter int unsigned JUMP_VEL         = 17,
  parameter int unsigned ULTRA_JUMP_VEL   = 23,
  parameter int unsigned GRAVITY          = 16,
  parameter int unsigned FASTFALL_GRAV    = 16,
  parameter int unsigned CUT_VEL          = 4,
  parameter int unsigned MAX_FALL_VEL     = 24,
  parameter int unsigned BUFFER_FRAMES    = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  dino_motion_if.slave bus
);
  localparam int unsigned PW    = COORD_W + FRAC_W + 1;
  localparam int unsigned BUF_W = $clog2(BUFFER_FRAMES + 1);

  typedef logic signed [PW-1:0] fx_t;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DUCK = 2'd1, ST_RISE = 2'd2, ST_FALL = 2'd3} state_t;

  localparam fx_t FLOOR_F = fx_t'(FLOOR_Y << FRAC_W);
  localparam fx_t JUMP_F  = fx_t'(JUMP_VEL << FRAC_W);
  localparam fx_t ULTRA_F = fx_t'(ULTRA_JUMP_VEL << FRAC_W);
  localparam fx_t GRAV_F  = fx_t'(GRAVITY);
  localparam fx_t FAST_F  = fx_t'(FASTFALL_GRAV);
  localparam fx_t CUT_F   = fx_t'(CUT_VEL << FRAC_W);
  localparam fx_t MAXF_F  = fx_t'(MAX_FALL_VEL << FRAC_W);
  localparam fx_t CEIL_STAND_F = fx_t'((2 * DINO_HALF_H) << FRAC_W);
  localparam fx_t CEIL_DUCK_F  = fx_t'((2 * DINO_DUCK_HALF_H) << FRAC_W);
  localparam logic [COORD_W-1:0] H_STAND = COORD_W'(2 * DINO_HALF_H);
  localparam logic [COORD_W-1:0] H_DUCK  = COORD_W'(2 * DINO_DUCK_HALF_H);

  state_t            state_q, state_d;
  fx_t               feet_q, feet_d;
  fx_t               vel_q, vel_d;
  logic [BUF_W-1:0]  buf_q, buf_d;
  logic              jump_prev_q;
  logic              tick;
  logic              jump_start_d, land_d;
  fx_t               grav, vel_cut, feet_sum, vel_sum, ceil_f;
  logic [COORD_W-1:0] h_out, y2_d;

  assign tick = bus.i_ani_stb & bus.i_animate;

  // Box x edges never move
  assign bus.o_x1 = COORD_W'(DINO_X - DINO_HALF_W);
  assign bus.o_x2 = COORD_W'(DINO_X + DINO_HALF_W);

  // Next-state and physics for one frame tick
  always_comb begin
    state_d      = state_q;
    feet_d       = feet_q;
    vel_d        = vel_q;
    buf_d        = buf_q;
    jump_start_d = 1'b0;
    land_d       = 1'b0;
    grav         = GRAV_F + (bus.i_duck ? FAST_F : fx_t'(0));
    ceil_f       = bus.i_duck ? CEIL_DUCK_F : CEIL_STAND_F;
    vel_cut      = vel_q;
    feet_sum     = feet_q + vel_q;
    vel_sum      = vel_q + grav;

    unique case (state_q)
      ST_RUN, ST_DUCK: begin
        // A pending buffered press only launches from RUN; DUCK needs the live button
        if (bus.i_jump || (state_q == ST_RUN && buf_q != '0)) begin
          state_d      = ST_RISE;
          vel_d        = bus.i_sss ? -ULTRA_F : -JUMP_F;
          buf_d        = '0;
          jump_start_d = 1'b1;
        end else if (state_q == ST_RUN && bus.i_duck) begin
          state_d = ST_DUCK;
        end else if (state_q == ST_DUCK && !bus.i_duck) begin
          state_d = ST_RUN;
        end
      end
      ST_RISE: begin
        // Releasing jump early caps the upward speed, which shortens the hop
        if (!bus.i_jump && vel_q < -CUT_F) vel_cut = -CUT_F;
        feet_sum = feet_q + vel_cut;
        if (feet_sum < ceil_f) begin
          feet_d  = ceil_f;
          vel_d   = '0;
          state_d = ST_FALL;
        end else begin
          feet_d = feet_sum;
          vel_d  = vel_cut + grav;
          if (!vel_d[PW-1]) state_d = ST_FALL;
        end
      end
      ST_FALL: begin
        if (feet_sum >= FLOOR_F) begin
          feet_d  = FLOOR_F;
          vel_d   = '0;
          land_d  = 1'b1;
          state_d = bus.i_duck ? ST_DUCK : ST_RUN;
        end else begin
          feet_d = feet_sum;
          vel_d  = (vel_sum > MAXF_F) ? MAXF_F : vel_sum;
        end
      end
    endcase

    // Airborne presses are remembered for a few frames so a slightly early press still jumps
    if (state_q == ST_RISE || state_q == ST_FALL) begin
      if (bus.i_jump && !jump_prev_q) buf_d = BUF_W'(BUFFER_FRAMES);
      else if (buf_q != '0)           buf_d = buf_q - BUF_W'(1);
    end

    // Box height follows the state being entered
    if (state_d == ST_DUCK || ((state_d == ST_RISE || state_d == ST_FALL) && bus.i_duck))
      h_out = H_DUCK;
    else
      h_out = H_STAND;
    y2_d = feet_d[FRAC_W +: COORD_W];
  end

  // State and output registers; everything holds between ticks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= ST_RUN;
      feet_q           <= FLOOR_F;
      vel_q            <= '0;
      buf_q            <= '0;
      jump_prev_q      <= 1'b0;
      bus.o_y1         <= COORD_W'(FLOOR_Y) - H_STAND;
      bus.o_y2         <= COORD_W'(FLOOR_Y);
      bus.o_state      <= ST_RUN;
      bus.o_jump_start <= 1'b0;
      bus.o_land       <= 1'b0;
    end else if (tick) begin
      state_q          <= state_d;
      feet_q           <= feet_d;
      vel_q            <= vel_d;
      buf_q            <= buf_d;
      jump_prev_q      <= bus.i_jump;
      bus.o_y1         <= y2_d - h_out;
      bus.o_y2         <= y2_d;
      bus.o_state      <= state_d;
      bus.o_jump_start <= jump_start_d;
      bus.o_land       <= land_d;
    end else begin
      bus.o_jump_start <= 1'b0;
      bus.o_land       <= 1'b0;
    end
  end
endmodule
